// File: rtl/spi_pkg.sv
// Shared SPI receive/transmit definitions: frame size, mode constants and
// FSM state encodings used by the receiver and the matching transmitter.
package spi_pkg;

  localparam int FRAME_W_DEF     = 24;
  localparam int SYNC_STAGES_DEF = 2;

  // Mode 0: clock idles low, data sampled on the rising edge.
  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RECV  = 2'b01,
    ST_CHECK = 2'b10
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchronizer for one asynchronous input, with a selectable
// reset level so each line powers up at its idle value.
module spi_sync #(
  parameter int   N       = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [N-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {N{RST_VAL}};
    else     r_sync <= (r_sync << 1) | N'(i_d);
  end

  assign o_q = r_sync[N-1];

endmodule

// File: rtl/spi_rx.sv
// Mode-0 SPI slave receiver: synchronizes the SPI lines into clk, shifts in
// MSB-first frames and hands complete frames out over a valid/ready port.
module spi_rx
  import spi_pkg::*;
#(
  parameter int FRAME_W     = FRAME_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               spi_cs,
  input  logic               spi_clk,
  input  logic               spi_data,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               frame_err,
  output logic               overflow,
  output logic               rx_busy
);

  localparam int CNT_W = $clog2(FRAME_W + 2);

  logic w_cs_s, w_sclk_s, w_data_s;
  logic r_cs_d, r_sclk_d;
  logic w_sclk_rise, w_cs_fall, w_cs_rise;

  spi_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]   r_cnt;
  logic [FRAME_W-1:0] r_shift;
  logic [FRAME_W-1:0] r_data;
  logic               r_valid, r_frame_err, r_overflow;
  logic               w_start, w_shift, w_load, w_ovf, w_err, w_hs, w_cnt_ok;

  // Equal depth on all three lines keeps data aligned with its clock edge.
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(RST), .i_d(spi_cs), .o_q(w_cs_s)
  );
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(RST), .i_d(spi_clk), .o_q(w_sclk_s)
  );
  spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst(RST), .i_d(spi_data), .o_q(w_data_s)
  );

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_hs        = r_valid & rx_ready;
  assign w_cnt_ok    = (r_cnt == CNT_W'(FRAME_W));

  always_ff @(posedge clk or posedge RST) begin
    if (RST) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    w_ovf       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Held-low select covers a new frame that began during ST_CHECK.
        if (w_cs_fall || (!w_cs_s && !r_cs_d)) begin
          w_state_nxt = ST_RECV;
          w_start     = 1'b1;
        end
      end
      ST_RECV: begin
        w_shift = w_sclk_rise;
        if (w_cs_rise) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_state_nxt = ST_IDLE;
        if (w_cnt_ok) begin
          if (!r_valid || w_hs) w_load = 1'b1;
          else                  w_ovf  = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_cs_d      <= w_cs_s;
      r_sclk_d    <= w_sclk_s;
      r_frame_err <= w_err;
      r_overflow  <= w_ovf;
      if (w_start) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[FRAME_W-2:0], w_data_s};
        if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule
